// File: rtl/z80_bus_pkg.sv
// Shared widths, FIFO entry layout and sizing helper for the Z80 I/O-write port.
package z80_bus_pkg;

   localparam int Z80_DATA_W = 8;
   localparam int Z80_ADDR_W = 2;
   localparam int Z80_CS_W   = 2;

   // One captured write at the default bus widths, register address in the upper bits.
   typedef struct packed {
      logic [Z80_ADDR_W-1:0] addr;
      logic [Z80_DATA_W-1:0] data;
   } z80_entry_t;

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is on rdata while the FIFO is non-empty,
// and rdata holds its last value once the FIFO empties.
module sync_fifo
   import z80_bus_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [WIDTH-1:0]          wdata,
   output logic [WIDTH-1:0]          rdata,
   output logic                      full,
   output logic                      empty,
   output logic [count_w(DEPTH)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             push_ok, pop_ok;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = rdata_q;

   // Accept/advance decisions and the next head value.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;

      pop_ok  = pop & ~empty;
      // A push into a full FIFO still fits when the head leaves in the same cycle.
      push_ok = push & (~full | pop_ok);

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // The head only moves on a pop, or when the first entry lands in an empty FIFO.
      if (pop_ok) begin
         if (count_q > CNT_W'(1)) rdata_d = mem_q[rd_ptr_d];
         else if (push_ok)        rdata_d = wdata;
      end else if (empty && push_ok) begin
         rdata_d = wdata;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   // Pointer, occupancy and head registers.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: rtl/z80_port_fifo.sv
// Z80 I/O-write port: synchronises the bus strobes, turns each write cycle into exactly
// one FIFO push of {addr, data}, stalls the CPU via wait_n when full and flags drops.
module z80_port_fifo
   import z80_bus_pkg::*;
#(
   parameter int DATA_W = Z80_DATA_W,
   parameter int ADDR_W = Z80_ADDR_W,
   parameter int CS_W   = Z80_CS_W,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      write,
   input  logic                      iorq,
   input  logic [CS_W-1:0]           chipsel,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         datain,
   output logic [DATA_W-1:0]         dataout,
   output logic [ADDR_W-1:0]         addrout,
   output logic                      valid,
   input  logic                      ready,
   output logic [count_w(DEPTH)-1:0] count,
   output logic                      overflow,
   input  logic                      ovf_clr,
   output logic                      wait_n
);

   logic sel_raw;
   logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic overflow_q, overflow_d;
   logic wait_n_q, wait_n_d;
   logic push_evt, pop, drop;
   logic full, empty;

   assign sel_raw = ~(write | iorq | (|chipsel));

   // Two-flop synchroniser plus history flop, rising-edge detect and status flags.
   always_comb begin
      s1_d = sel_raw;
      s2_d = s1_q;
      s3_d = s2_q;

      // One push per bus cycle no matter how long /WR stays low.
      push_evt = s2_q & ~s3_q;
      pop      = ~empty & ready;
      drop     = push_evt & full & ~pop;

      // A drop in the same cycle as a clear keeps the flag set.
      overflow_d = drop | (overflow_q & ~ovf_clr);
      wait_n_d   = ~full;
   end

   // Synchroniser, overflow and wait registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         overflow_q <= 1'b0;
         wait_n_q   <= 1'b1;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         overflow_q <= overflow_d;
         wait_n_q   <= wait_n_d;
      end
   end

   // addr/datain are sampled straight from the pins: the Z80 holds them stable for the
   // whole write cycle, which is longer than the synchroniser delay.
   sync_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_evt),
      .pop   (pop),
      .wdata ({addr, datain}),
      .rdata ({addrout, dataout}),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign valid    = ~empty;
   assign overflow = overflow_q;
   assign wait_n   = wait_n_q;

endmodule

// File: tb/tb_z80_port_fifo.sv
// Self-checking bench for z80_port_fifo: directed scenarios plus randomised bus traffic,
// compared every cycle against a queue-based reference model.
module tb_z80_port_fifo;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;
   localparam int CS_W   = 2;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              write = 1'b1;
   logic              iorq = 1'b1;
   logic [CS_W-1:0]   chipsel = '1;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] datain = '0;
   logic              ready = 1'b0;
   logic              ovf_clr = 1'b0;
   logic [DATA_W-1:0] dataout;
   logic [ADDR_W-1:0] addrout;
   logic              valid;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              wait_n;

   int checks = 0;
   int errors = 0;

   z80_port_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CS_W   (CS_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .write    (write),
      .iorq     (iorq),
      .chipsel  (chipsel),
      .addr     (addr),
      .datain   (datain),
      .dataout  (dataout),
      .addrout  (addrout),
      .valid    (valid),
      .ready    (ready),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr),
      .wait_n   (wait_n)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t              mq[$];
   bit                m_ovf = 1'b0;
   bit                m_wait = 1'b1;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_data = '0;
   // Select as seen at the previous one, two and three rising edges.
   bit                h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

   always @(posedge clk) begin
      bit   sel, push, pop, full, drop;
      ent_t e;
      if (!rst_n) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_wait = 1'b1;
         m_addr = '0;
         m_data = '0;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      end else begin
         sel  = !(write || iorq || (|chipsel));
         // A write first seen at edge n-2 is pushed at edge n.
         push = h2 && !h3;
         full = (mq.size() == DEPTH);
         pop  = (mq.size() != 0) && ready;
         drop = push && full && !pop;
         m_wait = !full;
         if (pop) void'(mq.pop_front());
         if (push && !drop) begin
            e = {addr, datain};
            mq.push_back(e);
         end
         if (drop) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         if (mq.size() != 0) begin
            m_addr = mq[0].a;
            m_data = mq[0].d;
         end
         h3 = h2; h2 = h1; h1 = sel;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and compare every output against the model.
   task automatic step(input string tag);
      @(posedge clk);
      @(negedge clk);
      check({tag, "/valid"},    32'(valid),    32'(mq.size() != 0));
      check({tag, "/count"},    32'(count),    32'(mq.size()));
      check({tag, "/wait_n"},   32'(wait_n),   32'(m_wait));
      check({tag, "/overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, "/dataout"},  32'(dataout),  32'(m_data));
      check({tag, "/addrout"},  32'(addrout),  32'(m_addr));
   endtask

   task automatic bus_sel(input bit on, input logic [CS_W-1:0] cs);
      write   = !on;
      iorq    = !on;
      chipsel = on ? cs : '1;
   endtask

   task automatic z80_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int low, input int high);
      addr   = a;
      datain = d;
      bus_sel(1'b1, '0);
      repeat (low) step("wr_low");
      bus_sel(1'b0, '0);
      repeat (high) step("wr_high");
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/rst_valid"},    32'(valid),    32'd0);
      check({tag, "/rst_count"},    32'(count),    32'd0);
      check({tag, "/rst_dataout"},  32'(dataout),  32'd0);
      check({tag, "/rst_addrout"},  32'(addrout),  32'd0);
      check({tag, "/rst_overflow"}, 32'(overflow), 32'd0);
      check({tag, "/rst_wait_n"},   32'(wait_n),   32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset.
      rst_n = 1'b0;
      repeat (2) step("reset");
      check_reset_values("reset");
      rst_n = 1'b1;
      step("post_reset");

      // Single write: valid rises exactly after the third edge.
      addr   = 2'd2;
      datain = 8'h5A;
      bus_sel(1'b1, '0);
      step("single_e1");
      check("single_e1_valid", 32'(valid), 32'd0);
      step("single_e2");
      check("single_e2_valid", 32'(valid), 32'd0);
      step("single_e3");
      check("single_e3_valid", 32'(valid), 32'd1);
      repeat (3) step("single_hold");
      bus_sel(1'b0, '0);
      repeat (2) step("single_high");
      check("single_addrout", 32'(addrout), 32'd2);
      check("single_dataout", 32'(dataout), 32'h5A);
      check("single_count",   32'(count),   32'd1);
      ready = 1'b1;
      step("single_pop");
      ready = 1'b0;
      check("single_pop_count", 32'(count), 32'd0);
      check("single_pop_valid", 32'(valid), 32'd0);

      // Partial chip select: no push.
      write   = 1'b0;
      iorq    = 1'b0;
      chipsel = 2'b01;
      repeat (5) step("cs_partial");
      bus_sel(1'b0, '0);
      repeat (2) step("cs_idle");
      check("cs_partial_count", 32'(count), 32'd0);

      // Fill to full, then one dropped write.
      for (int i = 1; i <= 3; i++) z80_write(ADDR_W'(i), DATA_W'(i), 3, 2);
      addr   = 2'd0;
      datain = 8'h04;
      bus_sel(1'b1, '0);
      repeat (3) step("fill4");
      check("fill4_count",  32'(count),  32'd4);
      check("fill4_wait_n", 32'(wait_n), 32'd1);
      step("fill4_next");
      check("fill4_next_wait_n", 32'(wait_n), 32'd0);
      bus_sel(1'b0, '0);
      repeat (2) step("fill4_high");
      z80_write(2'd1, 8'h05, 3, 2);
      check("drop_overflow", 32'(overflow), 32'd1);
      check("drop_count",    32'(count),    32'd4);
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("drain_%0d", i), 32'(dataout), 32'(i));
         step("drain");
      end
      ready = 1'b0;
      check("drain_valid", 32'(valid), 32'd0);
      check("drain_overflow_kept", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      step("ovf_clr");
      ovf_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO: push coincides with pop, across pointer wrap.
      for (int i = 0; i < 4; i++) z80_write(ADDR_W'(i), DATA_W'(8'h10 + i), 3, 2);
      check("coinc_pre_count", 32'(count), 32'd4);
      addr   = 2'd3;
      datain = 8'h14;
      bus_sel(1'b1, '0);
      repeat (2) step("coinc_e12");
      ready = 1'b1;
      step("coinc_e3");
      ready = 1'b0;
      check("coinc_count",    32'(count),    32'd4);
      check("coinc_overflow", 32'(overflow), 32'd0);
      check("coinc_head",     32'(dataout),  32'h11);
      repeat (3) step("coinc_hold");
      bus_sel(1'b0, '0);
      repeat (2) step("coinc_high");
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("coinc_drain_%0d", i), 32'(dataout), 32'(8'h10 + i));
         step("coinc_drain");
      end
      ready = 1'b0;

      // Reset while two entries are held and a write is in progress.
      z80_write(2'd1, 8'h21, 3, 2);
      z80_write(2'd2, 8'h22, 3, 2);
      check("mid_pre_count", 32'(count), 32'd2);
      addr   = 2'd3;
      datain = 8'h33;
      bus_sel(1'b1, '0);
      repeat (2) step("mid_low");
      rst_n = 1'b0;
      step("mid_reset");
      check_reset_values("mid_reset");
      rst_n = 1'b1;
      step("mid_e1");
      check("mid_e1_count", 32'(count), 32'd0);
      step("mid_e2");
      check("mid_e2_count", 32'(count), 32'd0);
      step("mid_e3");
      check("mid_e3_count", 32'(count),   32'd1);
      check("mid_e3_data",  32'(dataout), 32'h33);
      repeat (3) step("mid_hold");
      bus_sel(1'b0, '0);
      repeat (4) step("mid_high");
      check("mid_single_capture", 32'(count), 32'd1);
      ready = 1'b1;
      step("mid_drain");
      ready = 1'b0;

      // Randomised traffic: slow drain first (overflow, full+pop), then fast drain.
      for (int n = 0; n < 240; n++) begin
         int unsigned rdy_mod;
         int          low, high;
         logic [CS_W-1:0] cs;
         rdy_mod = (n < 120) ? 12 : 3;
         low  = $urandom_range(3, 6);
         high = $urandom_range(2, 4);
         cs   = ($urandom_range(0, 4) == 0) ? CS_W'($urandom_range(1, 3)) : '0;
         addr   = ADDR_W'($urandom);
         datain = DATA_W'($urandom);
         for (int c = 0; c < low + high; c++) begin
            bus_sel(c < low, cs);
            ready   = ($urandom_range(0, rdy_mod) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step("rand");
         end
      end
      ready   = 1'b0;
      ovf_clr = 1'b0;
      bus_sel(1'b0, '0);
      step("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/z80_port_fifo.md
# z80_port_fifo

Parametrised Z80 I/O-write port for the JML-8 mini-VGA peripheral. Synchronises the asynchronous Z80 strobes to `clk` and detects each I/O write bus cycle exactly once. Each write is captured as a {register address, data} entry in a FIFO, which the VGA-side logic drains over a valid/ready handshake. It also raises `wait_n` to stall the Z80 when the FIFO is full, and flags dropped writes.

## Interface
- `DATA_W`, 8: data bus width.
- `ADDR_W`, 2: register-select address bits (Z80 A[ADDR_W-1:0]).
- `CS_W`, 2: number of active-low chip-select lines; all must be low to select.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `write`  in  1  Z80 /WR, active-low, asynchronous.
- `iorq`  in  1  Z80 /IORQ, active-low, asynchronous.
- `chipsel`  in  CS_W  decoded selects, active-low, asynchronous.
- `addr`  in  ADDR_W  Z80 low address bits.
- `datain`  in  DATA_W  Z80 data bus.
- `dataout`  out  DATA_W  head-entry data.
- `addrout`  out  ADDR_W  head-entry register address.
- `valid`  out  1  head entry present.
- `ready`  in  1  consumer accepts head this cycle.
- `count`  out  $clog2(DEPTH+1)  entries held.
- `overflow`  out  1  sticky: a write was dropped.
- `ovf_clr`  in  1  clears `overflow`.
- `wait_n`  out  1  Z80 /WAIT, low while FIFO full.

## Operation
- `sel_raw = ~(write | iorq | |chipsel)`.
- `sel_raw` passes through two sync flops (s1, s2) plus a history flop s3. All three reset to 0.
- Push event: `s2 & ~s3`. This is one push per bus cycle, however long /WR is held.
- On a push event, `addr` and `datain` are sampled directly. They are stable for the whole Z80 write cycle, which spans ≥2 `clk` periods before the event.
- Pop: `valid & ready`. When `valid` is 0, `ready` is ignored.
- FIFO is first-word-fall-through.
  - `dataout`/`addrout` show the head entry whenever `valid` is 1.
  - When `valid` is 0, they hold their last value (0 after reset).
- Push when full:
  - With no simultaneous pop: the entry is dropped and `overflow` is set.
  - With a simultaneous pop: the push is accepted and `count` is unchanged.
- Push and pop in the same cycle when not full or empty: both occur and `count` is unchanged.
- Push into an empty FIFO while `ready` is 1: the entry appears first, and is popped on the next cycle at the earliest.
- `overflow` has priority set over clear: if `ovf_clr` and a drop occur together, `overflow` stays 1.
- `wait_n` is registered and equals `~full` as of the next cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` saturates at DEPTH by construction.
- Reset values: `valid` 0, `dataout` 0, `addrout` 0, `count` 0, `overflow` 0, `wait_n` 1.
- Reset mid-operation: the FIFO is emptied and the sync flops are cleared. A Z80 write still in progress when `rst_n` releases is captured once.

## Timing
- Edges are numbered from the first rising edge at which `sel_raw` = 1:
  - edge 1: s1 = 1.
  - edge 2: s2 = 1.
  - edge 3: push; `valid` is high after edge 3.
  - Latency from pins to `valid` is 3 cycles.
- Pop at edge k: the next entry, or `valid` = 0, is visible after edge k.
- Full at edge k: `wait_n` is low after edge k+1 and rises one cycle after the pop that clears full.
- Minimum /WR low width for capture is 3 `clk` periods. Minimum high width between writes is 2 periods.

## Structure
- Package `z80_bus_pkg` holds:
  - default widths (`Z80_DATA_W` = 8, `Z80_ADDR_W` = 2, `Z80_CS_W` = 2);
  - the packed entry typedef {addr, data};
  - the `clog2`-based count width helper.
- One sub-module, `sync_fifo`: parametrised FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty/count and synchronous active-low reset.
- `z80_port_fifo` contains the synchroniser, edge detector, overflow flag and `wait_n` register, and instantiates `sync_fifo`.

## Test plan
- Reset, then a single write (`addr`=2, `datain`=0x5A, select held low 6 cycles) -> exactly one entry: `valid` high after edge 3, `addrout`=2, `dataout`=0x5A, `count`=1. With `ready` = 1 -> `count`=0 and `valid`=0.
- `chipsel`=2'b01 with /WR and /IORQ low -> no push; `count` stays 0.
- DEPTH=4, five writes 0x01..0x05 with `ready`=0:
  - `wait_n`=0 one cycle after the 4th push;
  - 5th write dropped and `overflow`=1;
  - draining yields 0x01..0x04 in order;
  - `ovf_clr` clears `overflow`.
- FIFO full, and a push event coincides with a pop -> push accepted, `count` stays 4, no overflow; head order preserved across pointer wrap.
- `rst_n` low for one cycle while 2 entries are held and /WR is low -> after release: `count` 0, then a single re-capture of the in-progress write; all outputs at reset values during reset.
